neck_diff: RTL and testbench

- Upstream stage of the neck-detection path; feeds the neck judge's first/second/third-order inputs and its en_judge strobe.
- Takes raw arc-voltage ADC samples and smooths them with a power-of-two moving average.
- Computes first-, second- and third-order backward differences of the averaged stream, saturates each to 13-bit signed, and emits one en_judge pulse per processed sample once the pipeline is primed.

---
 rtl/neck_diff.sv | 228 ++++++++++++++++++++++
 tb/tb_neck_diff.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/neck_diff.sv
// neck_diff: moving-average smoothing of arc-voltage ADC samples followed by
// first/second/third-order backward differences, saturated for the neck judge.
// Two pipeline stages: stage 1 holds the averaged sample, stage 2 holds the
// difference history and the saturated outputs with the en_judge strobe.
module neck_diff #(
  parameter int DATA_W    = 12,
  parameter int OUT_W     = 13,
  parameter int AVG_SHIFT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     det_en,
  input  logic [DATA_W-1:0]        ad_data,
  input  logic                     ad_valid,
  output logic signed [OUT_W-1:0]  first_order_data,
  output logic signed [OUT_W-1:0]  second_order_data,
  output logic signed [OUT_W-1:0]  third_order_data,
  output logic                     en_judge,
  output logic                     primed
);

  localparam int AVG_LEN  = 1 << AVG_SHIFT;
  localparam int SUM_W    = DATA_W + AVG_SHIFT;
  localparam int D1_W     = DATA_W + 1;
  localparam int D2_W     = DATA_W + 2;
  localparam int D3_W     = DATA_W + 3;
  // Samples needed before the third difference is built from real data only.
  localparam int FILL_LEN = AVG_LEN + 3;
  localparam int CNT_W    = $clog2(FILL_LEN + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FILL_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILL_LEN - 1);

  localparam logic signed [D3_W-1:0] SAT_MAX = D3_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [D3_W-1:0] SAT_MIN = D3_W'(-(1 << (OUT_W - 1)));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Averaging window and running sum.
  logic [DATA_W-1:0] window [AVG_LEN];
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  sum_next;

  // Priming counter.
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;

  logic              accept;
  logic              emit;

  // Stage 1 registers.
  logic              s1_valid;
  logic              s1_emit;
  logic [DATA_W-1:0] s1_avg;

  // Difference history (unsaturated).
  logic [DATA_W-1:0]      avg_prev;
  logic signed [D1_W-1:0] d1_prev;
  logic signed [D2_W-1:0] d2_prev;

  logic signed [D1_W-1:0] d1;
  logic signed [D2_W-1:0] d2;
  logic signed [D3_W-1:0] d3;

  // A sample is only taken while detection is enabled; det_en low drops it.
  assign accept = det_en & ad_valid;
  assign primed = (state == RUN);

  // Clamp a wide signed difference into the output range.
  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [D3_W-1:0] v);
    logic signed [D3_W-1:0] c;
    if (v > SAT_MAX) begin
      c = SAT_MAX;
    end else if (v < SAT_MIN) begin
      c = SAT_MIN;
    end else begin
      c = v;
    end
    return c[OUT_W-1:0];
  endfunction

  // Running sum update: add the newest sample, drop the oldest one in the window.
  always_comb begin
    sum_next = sum + SUM_W'(ad_data) - SUM_W'(window[AVG_LEN-1]);
  end

  // Window shift register; flushed to zero whenever detection is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < AVG_LEN; i++) begin
        window[i] <= '0;
      end
    end else if (!det_en) begin
      for (int i = 0; i < AVG_LEN; i++) begin
        window[i] <= '0;
      end
    end else if (accept) begin
      window[0] <= ad_data;
      for (int i = 1; i < AVG_LEN; i++) begin
        window[i] <= window[i-1];
      end
    end
  end

  // Running sum register, kept consistent with the window contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (!det_en) begin
      sum <= '0;
    end else if (accept) begin
      sum <= sum_next;
    end
  end

  // Next-state, saturating priming counter and emit decision for this sample.
  always_comb begin
    state_next = state;
    count_next = count;
    emit       = 1'b0;
    if (!det_en) begin
      state_next = IDLE;
      count_next = '0;
    end else begin
      if (accept && (count != CNT_FULL)) begin
        count_next = count + 1'b1;
      end
      case (state)
        IDLE: begin
          state_next = FILL;
        end
        FILL: begin
          if (accept && (count == CNT_LAST)) begin
            state_next = RUN;
            emit       = 1'b1;
          end
        end
        RUN: begin
          emit = accept;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State register and priming counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Stage 1: register the truncated average together with its valid/emit tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_emit  <= 1'b0;
      s1_avg   <= '0;
    end else if (!det_en) begin
      s1_valid <= 1'b0;
      s1_emit  <= 1'b0;
      s1_avg   <= '0;
    end else begin
      s1_valid <= accept;
      s1_emit  <= emit;
      if (accept) begin
        s1_avg <= DATA_W'(sum_next >> AVG_SHIFT);
      end
    end
  end

  // Exact-width differences built from unsaturated history.
  always_comb begin
    d1 = $signed({1'b0, s1_avg}) - $signed({1'b0, avg_prev});
    d2 = $signed({d1[D1_W-1], d1}) - $signed({d1_prev[D1_W-1], d1_prev});
    d3 = $signed({d2[D2_W-1], d2}) - $signed({d2_prev[D2_W-1], d2_prev});
  end

  // Stage 2 history: advance on every stage-1 sample, cleared on disable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg_prev <= '0;
      d1_prev  <= '0;
      d2_prev  <= '0;
    end else if (!det_en) begin
      avg_prev <= '0;
      d1_prev  <= '0;
      d2_prev  <= '0;
    end else if (s1_valid) begin
      avg_prev <= s1_avg;
      d1_prev  <= d1;
      d2_prev  <= d2;
    end
  end

  // Stage 2 outputs: update and strobe only for primed samples; hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_order_data  <= '0;
      second_order_data <= '0;
      third_order_data  <= '0;
      en_judge          <= 1'b0;
    end else if (!det_en) begin
      en_judge <= 1'b0;
    end else begin
      en_judge <= s1_valid & s1_emit;
      if (s1_valid && s1_emit) begin
        first_order_data  <= saturate({{2{d1[D1_W-1]}}, d1});
        second_order_data <= saturate({d2[D2_W-1], d2});
        third_order_data  <= saturate(d3);
      end
    end
  end

endmodule

// File: tb/tb_neck_diff.sv
// tb_neck_diff: directed checks of neck_diff (default averaging) and a second
// instance with AVG_SHIFT=0 for the saturation cases. Inputs change on the
// falling edge; outputs are observed on the falling edge after each cycle.
module tb_neck_diff;

  logic clk = 1'b0;
  logic rst_n;
  logic det_en;
  logic ad_valid;
  logic [11:0] ad_data;

  logic signed [12:0] first_order_data;
  logic signed [12:0] second_order_data;
  logic signed [12:0] third_order_data;
  logic en_judge;
  logic primed;

  logic signed [12:0] sat_first;
  logic signed [12:0] sat_second;
  logic signed [12:0] sat_third;
  logic sat_en;
  logic sat_primed;

  int total = 0;
  int bad   = 0;

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  neck_diff u_dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .det_en            (det_en),
    .ad_data           (ad_data),
    .ad_valid          (ad_valid),
    .first_order_data  (first_order_data),
    .second_order_data (second_order_data),
    .third_order_data  (third_order_data),
    .en_judge          (en_judge),
    .primed            (primed)
  );

  neck_diff #(.AVG_SHIFT(0)) u_sat (
    .clk               (clk),
    .rst_n             (rst_n),
    .det_en            (det_en),
    .ad_data           (ad_data),
    .ad_valid          (ad_valid),
    .first_order_data  (sat_first),
    .second_order_data (sat_second),
    .third_order_data  (sat_third),
    .en_judge          (sat_en),
    .primed            (sat_primed)
  );

  // Drive one cycle of inputs and return on the next falling edge.
  task automatic applyStimulus(input logic en, input logic v, input logic [11:0] d);
    det_en   = en;
    ad_valid = v;
    ad_data  = d;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 12'd0);
    applyStimulus(1'b0, 1'b0, 12'd0);
    total++; if (first_order_data !== 13'sd0) begin bad++; $display("[TB] FAIL reset_first got=%0d want=0", first_order_data); end
    total++; if (second_order_data !== 13'sd0) begin bad++; $display("[TB] FAIL reset_second got=%0d want=0", second_order_data); end
    total++; if (third_order_data !== 13'sd0) begin bad++; $display("[TB] FAIL reset_third got=%0d want=0", third_order_data); end
    total++; if (en_judge !== 1'b0) begin bad++; $display("[TB] FAIL reset_en got=%0b want=0", en_judge); end
    total++; if (primed !== 1'b0) begin bad++; $display("[TB] FAIL reset_primed got=%0b want=0", primed); end
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b0, (c % 2) == 0, 12'(c * 300 + 7));
      total++; if (en_judge !== 1'b0) begin bad++; $display("[TB] FAIL idle_en c=%0d got=%0b want=0", c, en_judge); end
      total++; if (primed !== 1'b0) begin bad++; $display("[TB] FAIL idle_primed c=%0d got=%0b want=0", c, primed); end
      total++; if (first_order_data !== 13'sd0) begin bad++; $display("[TB] FAIL idle_first c=%0d got=%0d want=0", c, first_order_data); end
    end
  endtask

  task automatic test_priming();
    logic exp_en;
    logic exp_primed;
    int pulses;
    pulses = 0;
    applyStimulus(1'b0, 1'b0, 12'd0);
    for (int c = 0; c < 32; c++) begin
      applyStimulus(1'b1, ((c % 3) == 0) && ((c / 3) < 10), 12'd2000);
      exp_en = (c >= 1) && (((c - 1) % 3) == 0) && (((c - 1) / 3) >= 6) && (((c - 1) / 3) <= 9);
      exp_primed = (c >= 18);
      total++; if (en_judge !== exp_en) begin bad++; $display("[TB] FAIL prime_en c=%0d got=%0b want=%0b", c, en_judge, exp_en); end
      total++; if (primed !== exp_primed) begin bad++; $display("[TB] FAIL prime_primed c=%0d got=%0b want=%0b", c, primed, exp_primed); end
      if (en_judge === 1'b1) pulses++;
      if (exp_en) begin
        total++; if (first_order_data !== 13'sd0) begin bad++; $display("[TB] FAIL const_first c=%0d got=%0d want=0", c, first_order_data); end
        total++; if (second_order_data !== 13'sd0) begin bad++; $display("[TB] FAIL const_second c=%0d got=%0d want=0", c, second_order_data); end
        total++; if (third_order_data !== 13'sd0) begin bad++; $display("[TB] FAIL const_third c=%0d got=%0d want=0", c, third_order_data); end
      end
    end
    total++; if (pulses != 4) begin bad++; $display("[TB] FAIL prime_pulses got=%0d want=4", pulses); end
  endtask

  task automatic test_ramp();
    logic exp_en;
    int pulses;
    pulses = 0;
    applyStimulus(1'b0, 1'b0, 12'd0);
    for (int c = 0; c < 26; c++) begin
      applyStimulus(1'b1, ((c % 2) == 0) && ((c / 2) < 12), 12'(100 + 16 * (c / 2)));
      exp_en = (c >= 1) && (((c - 1) % 2) == 0) && (((c - 1) / 2) >= 6) && (((c - 1) / 2) <= 11);
      total++; if (en_judge !== exp_en) begin bad++; $display("[TB] FAIL ramp_en c=%0d got=%0b want=%0b", c, en_judge, exp_en); end
      if (en_judge === 1'b1) pulses++;
      if (exp_en) begin
        total++; if (first_order_data !== 13'sd16) begin bad++; $display("[TB] FAIL ramp_first c=%0d got=%0d want=16", c, first_order_data); end
        total++; if (second_order_data !== 13'sd0) begin bad++; $display("[TB] FAIL ramp_second c=%0d got=%0d want=0", c, second_order_data); end
        total++; if (third_order_data !== 13'sd0) begin bad++; $display("[TB] FAIL ramp_third c=%0d got=%0d want=0", c, third_order_data); end
      end
    end
    total++; if (pulses != 6) begin bad++; $display("[TB] FAIL ramp_pulses got=%0d want=6", pulses); end
  endtask

  task automatic test_saturation();
    logic [11:0] vals [5];
    logic signed [12:0] exp_first [2];
    logic signed [12:0] exp_second [2];
    logic signed [12:0] exp_third [2];
    logic exp_en;
    int idx;
    vals = '{12'd0, 12'd4095, 12'd0, 12'd4095, 12'd0};
    exp_first  = '{13'sd4095, -13'sd4095};
    exp_second = '{13'sd4095, -13'sd4096};
    exp_third  = '{13'sd4095, -13'sd4096};
    applyStimulus(1'b0, 1'b0, 12'd0);
    for (int c = 0; c < 11; c++) begin
      applyStimulus(1'b1, ((c % 2) == 0) && ((c / 2) < 5), vals[(c / 2) % 5]);
      idx = (c - 1) / 2;
      exp_en = (c >= 1) && (((c - 1) % 2) == 0) && (idx >= 3) && (idx <= 4);
      total++; if (sat_en !== exp_en) begin bad++; $display("[TB] FAIL sat_en c=%0d got=%0b want=%0b", c, sat_en, exp_en); end
      total++; if (en_judge !== 1'b0) begin bad++; $display("[TB] FAIL sat_main_en c=%0d got=%0b want=0", c, en_judge); end
      if (exp_en) begin
        total++; if (sat_first !== exp_first[idx - 3]) begin bad++; $display("[TB] FAIL sat_first c=%0d got=%0d want=%0d", c, sat_first, exp_first[idx - 3]); end
        total++; if (sat_second !== exp_second[idx - 3]) begin bad++; $display("[TB] FAIL sat_second c=%0d got=%0d want=%0d", c, sat_second, exp_second[idx - 3]); end
        total++; if (sat_third !== exp_third[idx - 3]) begin bad++; $display("[TB] FAIL sat_third c=%0d got=%0d want=%0d", c, sat_third, exp_third[idx - 3]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_en;
    int pulses;
    pulses = 0;
    applyStimulus(1'b0, 1'b0, 12'd0);
    for (int c = 0; c < 22; c++) begin
      applyStimulus(1'b1, c < 20, 12'(500 + 16 * c));
      exp_en = (c >= 7) && (c <= 20);
      total++; if (en_judge !== exp_en) begin bad++; $display("[TB] FAIL b2b_en c=%0d got=%0b want=%0b", c, en_judge, exp_en); end
      if (en_judge === 1'b1) pulses++;
      if (exp_en) begin
        total++; if (first_order_data !== 13'sd16) begin bad++; $display("[TB] FAIL b2b_first c=%0d got=%0d want=16", c, first_order_data); end
        total++; if (second_order_data !== 13'sd0) begin bad++; $display("[TB] FAIL b2b_second c=%0d got=%0d want=0", c, second_order_data); end
        total++; if (third_order_data !== 13'sd0) begin bad++; $display("[TB] FAIL b2b_third c=%0d got=%0d want=0", c, third_order_data); end
      end
    end
    total++; if (pulses != 14) begin bad++; $display("[TB] FAIL b2b_pulses got=%0d want=14", pulses); end
  endtask

  task automatic test_flush_reset();
    logic exp_en;
    logic exp_primed;
    applyStimulus(1'b0, 1'b0, 12'd0);
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b1, 1'b1, 12'(1000 + 16 * c));
    end
    total++; if (en_judge !== 1'b1) begin bad++; $display("[TB] FAIL run_en got=%0b want=1", en_judge); end
    total++; if (primed !== 1'b1) begin bad++; $display("[TB] FAIL run_primed got=%0b want=1", primed); end
    // Disable for one cycle together with a sample while another is in flight.
    applyStimulus(1'b0, 1'b1, 12'd1128);
    total++; if (en_judge !== 1'b0) begin bad++; $display("[TB] FAIL flush_en0 got=%0b want=0", en_judge); end
    total++; if (primed !== 1'b0) begin bad++; $display("[TB] FAIL flush_primed got=%0b want=0", primed); end
    applyStimulus(1'b1, 1'b0, 12'd0);
    total++; if (en_judge !== 1'b0) begin bad++; $display("[TB] FAIL flush_en1 got=%0b want=0", en_judge); end
    // Re-prime with a fresh ramp.
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b1, 1'b1, 12'(2000 + 16 * c));
      exp_en = (c == 7);
      exp_primed = (c >= 6);
      total++; if (en_judge !== exp_en) begin bad++; $display("[TB] FAIL reprime_en c=%0d got=%0b want=%0b", c, en_judge, exp_en); end
      total++; if (primed !== exp_primed) begin bad++; $display("[TB] FAIL reprime_primed c=%0d got=%0b want=%0b", c, primed, exp_primed); end
      if (exp_en) begin
        total++; if (first_order_data !== 13'sd16) begin bad++; $display("[TB] FAIL reprime_first got=%0d want=16", first_order_data); end
      end
    end
    applyStimulus(1'b1, 1'b1, 12'd2128);
    total++; if (en_judge !== 1'b1) begin bad++; $display("[TB] FAIL prereset_en got=%0b want=1", en_judge); end
    // Asynchronous reset in the middle of the stream.
    rst_n = 1'b0;
    #1;
    total++; if (first_order_data !== 13'sd0) begin bad++; $display("[TB] FAIL midreset_first got=%0d want=0", first_order_data); end
    total++; if (second_order_data !== 13'sd0) begin bad++; $display("[TB] FAIL midreset_second got=%0d want=0", second_order_data); end
    total++; if (third_order_data !== 13'sd0) begin bad++; $display("[TB] FAIL midreset_third got=%0d want=0", third_order_data); end
    total++; if (en_judge !== 1'b0) begin bad++; $display("[TB] FAIL midreset_en got=%0b want=0", en_judge); end
    total++; if (primed !== 1'b0) begin bad++; $display("[TB] FAIL midreset_primed got=%0b want=0", primed); end
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 12'd2144);
    applyStimulus(1'b1, 1'b1, 12'd2160);
    rst_n = 1'b1;
    // After release the block must collect a full priming run again.
    for (int c = 0; c < 9; c++) begin
      applyStimulus(1'b1, c < 7, 12'(3000 + 16 * c));
      exp_en = (c == 7);
      exp_primed = (c >= 6);
      total++; if (en_judge !== exp_en) begin bad++; $display("[TB] FAIL postreset_en c=%0d got=%0b want=%0b", c, en_judge, exp_en); end
      total++; if (primed !== exp_primed) begin bad++; $display("[TB] FAIL postreset_primed c=%0d got=%0b want=%0b", c, primed, exp_primed); end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    rst_n    = 1'b0;
    det_en   = 1'b0;
    ad_valid = 1'b0;
    ad_data  = 12'd0;
    test_reset();
    test_priming();
    test_ramp();
    test_saturation();
    test_back_to_back();
    test_flush_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
